grover_seq_ctrl: RTL and testbench
==================================

// Module: grover_seq_ctrl
// PURPOSE
// Sequencer for the 3-qubit Grover amplitude datapath: 8 signed 8-bit amplitude registers
// behind a 3-way source mux (uniform-init / oracle / diffusion). It drives the bank's
// load enable and the mux select, steps INIT -> (ORACLE -> DIFFUSE) x N, and reports
// completion over a start/done handshake. It sits between the top-level control and the bank.
// PARAMETERS
// NUM_ITER   2   default Grover iteration count, used when iter_cfg==0 (2 is optimal for 8 states)
// STAGE_LAT  1   cycles per stage for the datapath to settle; legal range 1..255
// ITER_W     4   width of iter_cfg and iter_cnt
// PORTS
// clk        in   1       clock, rising edge
// rst        in   1       synchronous reset, active-high
// start      in   1       begin a run; sampled only in IDLE
// abort      in   1       cancel the active run
// iter_cfg   in   ITER_W  iteration count for this run; 0 selects NUM_ITER; latched at start
// reg_en     out  1       load enable to the amplitude register bank
// src_sel    out  2       bank input mux: 0=uniform init, 1=oracle, 2=diffusion (3 unused)
// busy       out  1       high while in INIT, ORACLE or DIFF
// done       out  1       one-cycle pulse when a run completes
// iter_cnt   out  ITER_W  number of completed oracle+diffusion iterations in this run
// BEHAVIOUR
// - States are IDLE, INIT, ORACLE, DIFF and DONE. All state is updated on the rising clk edge.
// - rst=1: state=IDLE, wait_cnt=0, iter_cnt=0, n_iter=0. All outputs read 0 in the next cycle.
//   This applies mid-run as well. rst overrides start and abort.
// - IDLE: if start=1, latch n_iter = (iter_cfg==0 ? NUM_ITER : iter_cfg), clear iter_cnt,
//   and move to INIT.
// - Stage states (INIT/ORACLE/DIFF): wait_cnt (8 bit) counts 0..STAGE_LAT-1.
//   reg_en=1 only in the cycle where wait_cnt==STAGE_LAT-1; that cycle is the commit cycle.
//   The bank captures the data on the clk edge that ends the commit cycle.
//   wait_cnt returns to 0 on every state change.
// - src_sel is combinational from state: INIT=0, ORACLE=1, DIFF=2, and 0 in IDLE/DONE.
// - Transitions on commit:
//   - INIT -> ORACLE.
//   - ORACLE -> DIFF.
//   - DIFF: iter_cnt increments. If iter_cnt+1==n_iter go to DONE, otherwise go to ORACLE.
// - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. iter_cnt holds its value
//   until the next start.
// - busy=1 in INIT, ORACLE and DIFF only. It is combinational from state.
// - abort=1 in a stage state: reg_en is forced to 0 in that cycle and the next state is IDLE.
//   No done pulse is produced and iter_cnt keeps the completed count. abort in IDLE/DONE
//   has no effect.
// - start while busy or in DONE is ignored (not queued).
// - Run latency from the start-sampling edge to the done cycle:
//   (1 + 2*n_iter)*STAGE_LAT + 1 cycles. Example: STAGE_LAT=1, n=2 gives done 6 cycles after start.
// - iter_cfg is ignored outside IDLE. Mid-run changes have no effect.
// TESTING
// - STAGE_LAT=1, iter_cfg=2, start pulse at cycle 0:
//   -> reg_en=1 on cycles 1..5 with src_sel 0,1,2,1,2; done=1 at cycle 6; iter_cnt=2.
// - STAGE_LAT=3, iter_cfg=3:
//   -> each stage lasts 3 cycles with reg_en only on its 3rd cycle; 7 reg_en pulses;
//   done 22 cycles after start; busy high for 21 cycles.
// - iter_cfg=0, NUM_ITER=2:
//   -> behaves identically to iter_cfg=2 (same reg_en/src_sel trace).
// - abort during the 2nd ORACLE commit cycle (STAGE_LAT=1, n=2):
//   -> reg_en=0 in that cycle; IDLE next; done never pulses; iter_cnt=1.
// - start re-asserted while busy:
//   -> the trace is unchanged from the single-start case.
// - rst=1 during DIFF:
//   -> the next cycle shows IDLE with busy=0, reg_en=0, done=0, iter_cnt=0;
//   a new start then runs normally.

Source files
------------

// File: rtl/grover_seq_ctrl.sv
// Sequencer for the 3-qubit Grover amplitude bank: steps INIT -> (ORACLE -> DIFF) x n,
// driving the bank load enable and source mux, with a start/done handshake.
//
// state  | meaning
// IDLE   | waiting for start
// INIT   | loading uniform superposition
// ORACLE | loading oracle-marked amplitudes
// DIFF   | loading diffusion result, counts one iteration
// DONE   | one-cycle completion pulse
module grover_seq_ctrl #(
  parameter int NUM_ITER  = 2,
  parameter int STAGE_LAT = 1,
  parameter int ITER_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] iter_cfg,
  output logic              reg_en,
  output logic [1:0]        src_sel,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ORACLE,
    S_DIFF,
    S_DONE
  } state_t;

  localparam logic [7:0]        LAST_CNT  = 8'(STAGE_LAT - 1);
  localparam logic [ITER_W-1:0] DEF_ITER  = ITER_W'(NUM_ITER);
  localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);

  state_t            state;
  logic [7:0]        wait_cnt;
  logic [ITER_W-1:0] n_iter;
  logic [ITER_W-1:0] iter_nxt;
  logic              stage;
  logic              commit;

  assign stage    = (state == S_INIT) || (state == S_ORACLE) || (state == S_DIFF);
  assign commit   = stage && (wait_cnt == LAST_CNT);
  assign iter_nxt = iter_cnt + ITER_ONE;

  // abort suppresses the bank load in the same cycle it is seen
  assign reg_en = commit && !abort;
  assign busy   = stage;
  assign done   = (state == S_DONE);

  always_comb begin
    src_sel = 2'd0;
    case (state)
      S_ORACLE: src_sel = 2'd1;
      S_DIFF:   src_sel = 2'd2;
      default:  src_sel = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= 8'd0;
      iter_cnt <= '0;
      n_iter   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          wait_cnt <= 8'd0;
          if (start) begin
            n_iter   <= (iter_cfg == '0) ? DEF_ITER : iter_cfg;
            iter_cnt <= '0;
            state    <= S_INIT;
          end
        end
        S_INIT, S_ORACLE, S_DIFF: begin
          if (abort) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
          end else if (commit) begin
            wait_cnt <= 8'd0;
            case (state)
              S_INIT:   state <= S_ORACLE;
              S_ORACLE: state <= S_DIFF;
              default: begin
                iter_cnt <= iter_nxt;
                state    <= (iter_nxt == n_iter) ? S_DONE : S_ORACLE;
              end
            endcase
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DONE: begin
          wait_cnt <= 8'd0;
          state    <= S_IDLE;
        end
        default: begin
          wait_cnt <= 8'd0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grover_seq_ctrl.sv
// Scoreboard bench for grover_seq_ctrl: stimulus queues expected reg_en/done events,
// negedge monitors pop and compare them against two instances (STAGE_LAT 1 and 3).
module tb_grover_seq_ctrl;

  typedef struct {
    int         cyc;
    bit         kind;   // 0 = reg_en commit, 1 = done pulse
    logic [1:0] src;
    logic [3:0] icnt;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, abort1, start3, abort3;
  logic [3:0] cfg1, cfg3;
  logic       reg_en1, busy1, done1, reg_en3, busy3, done3;
  logic [1:0] src1, src3;
  logic [3:0] iter_cnt1, iter_cnt3;

  int  cyc = 0;
  int  tests = 0;
  int  failed = 0;
  int  bcnt1 = 0;
  int  bcnt3 = 0;
  ev_t q1[$];
  ev_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  grover_seq_ctrl #(.NUM_ITER(2), .STAGE_LAT(1), .ITER_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .iter_cfg(cfg1),
    .reg_en(reg_en1), .src_sel(src1), .busy(busy1), .done(done1), .iter_cnt(iter_cnt1)
  );

  grover_seq_ctrl #(.NUM_ITER(2), .STAGE_LAT(3), .ITER_W(4)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .iter_cfg(cfg3),
    .reg_en(reg_en3), .src_sel(src3), .busy(busy3), .done(done3), .iter_cnt(iter_cnt3)
  );

  task automatic mon(input int id, input logic re, input logic dn,
                     input logic [1:0] s, input logic [3:0] ic);
    ev_t e;
    bit  empty;
    empty = (id == 1) ? (q1.size() == 0) : (q3.size() == 0);
    tests++;
    if (empty) begin
      failed++;
      $display("FAIL dut%0d unexpected_event: cyc=%0d reg_en=%0b done=%0b src=%0d iter=%0d, required no event",
               id, cyc, re, dn, s, ic);
    end else begin
      if (id == 1) e = q1.pop_front();
      else         e = q3.pop_front();
      if (!(e.cyc == cyc && re == !e.kind && dn == e.kind && s == e.src && ic == e.icnt)) begin
        failed++;
        $display("FAIL dut%0d event: got cyc=%0d reg_en=%0b done=%0b src=%0d iter=%0d, required cyc=%0d reg_en=%0b done=%0b src=%0d iter=%0d",
                 id, cyc, re, dn, s, ic, e.cyc, !e.kind, e.kind, e.src, e.icnt);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (busy1) bcnt1++;
      if (busy3) bcnt3++;
      if (reg_en1 || done1) mon(1, reg_en1, done1, src1, iter_cnt1);
      if (reg_en3 || done3) mon(3, reg_en3, done3, src3, iter_cnt3);
    end
  end

  // nst < 0 queues the full run plus done; otherwise only the first nst commits
  task automatic push_run(input int id, input int c0, input int l, input int n, input int nst);
    ev_t e;
    for (int j = 0; j <= 2 * n; j++) begin
      if (nst < 0 || j < nst) begin
        e.cyc  = c0 + (j + 1) * l;
        e.kind = 1'b0;
        e.src  = (j == 0) ? 2'd0 : ((j % 2 == 1) ? 2'd1 : 2'd2);
        e.icnt = (j == 0) ? 4'd0 : 4'((j - 1) / 2);
        if (id == 1) q1.push_back(e); else q3.push_back(e);
      end
    end
    if (nst < 0) begin
      e.cyc  = c0 + (2 * n + 1) * l + 1;
      e.kind = 1'b1;
      e.src  = 2'd0;
      e.icnt = 4'(n);
      if (id == 1) q1.push_back(e); else q3.push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      failed++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic check_empty(input string name);
    check({name, "_leftover1"}, q1.size(), 0);
    check({name, "_leftover3"}, q3.size(), 0);
    q1.delete();
    q3.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; cfg1 = 4'd0;
    start3 = 1'b0; abort3 = 1'b0; cfg3 = 4'd0;
    tick(3);
    rst = 1'b0;
    check("reset_outputs1", {reg_en1, src1, busy1, done1, iter_cnt1}, 0);
    check("reset_outputs3", {reg_en3, src3, busy3, done3, iter_cnt3}, 0);
    tick(2);

    // basic run, n=2, STAGE_LAT=1
    cfg1 = 4'd2; start1 = 1'b1; c0 = cyc; bcnt1 = 0;
    push_run(1, c0, 1, 2, -1);
    tick(1); start1 = 1'b0;
    tick(10);
    check_empty("run_n2");
    check("busy_cycles_n2", bcnt1, 5);
    check("iter_hold_n2", iter_cnt1, 2);

    // iter_cfg=0 falls back to NUM_ITER
    cfg1 = 4'd0; start1 = 1'b1; c0 = cyc;
    push_run(1, c0, 1, 2, -1);
    tick(1); start1 = 1'b0;
    tick(10);
    check_empty("run_cfg0");
    check("iter_hold_cfg0", iter_cnt1, 2);

    // start while busy / in DONE and mid-run cfg change are ignored
    cfg1 = 4'd2; start1 = 1'b1; c0 = cyc;
    push_run(1, c0, 1, 2, -1);
    tick(1); start1 = 1'b0; cfg1 = 4'd5;
    tick(1); start1 = 1'b1;
    tick(1); start1 = 1'b0;
    tick(1); start1 = 1'b1;
    tick(1); start1 = 1'b0;
    tick(1); start1 = 1'b1;   // cycle c0+6 is DONE
    check("done_cycle_restart", done1, 1);
    tick(1); start1 = 1'b0;
    check("idle_after_ignored_start", busy1, 0);
    tick(10);
    check_empty("run_restart");

    // abort during the 2nd ORACLE commit cycle
    cfg1 = 4'd2; start1 = 1'b1; c0 = cyc;
    push_run(1, c0, 1, 2, 3);
    tick(1); start1 = 1'b0;
    tick(3); abort1 = 1'b1;
    check("abort_cycle_src", src1, 1);
    tick(1); abort1 = 1'b0;
    check("abort_busy_next", busy1, 0);
    tick(10);
    check("abort_iter_cnt", iter_cnt1, 1);
    check_empty("run_abort");

    // abort in IDLE has no effect on a following start
    abort1 = 1'b1; tick(1); abort1 = 1'b0;
    cfg1 = 4'd1; start1 = 1'b1; c0 = cyc;
    push_run(1, c0, 1, 1, -1);
    tick(1); start1 = 1'b0;
    tick(8);
    check_empty("run_n1");
    check("iter_hold_n1", iter_cnt1, 1);

    // STAGE_LAT=3, n=3
    cfg3 = 4'd3; start3 = 1'b1; c0 = cyc; bcnt3 = 0;
    push_run(3, c0, 3, 3, -1);
    tick(1); start3 = 1'b0;
    tick(30);
    check_empty("run_lat3");
    check("busy_cycles_lat3", bcnt3, 21);
    check("iter_hold_lat3", iter_cnt3, 3);

    // synchronous reset during DIFF, then a fresh run
    cfg1 = 4'd2; start1 = 1'b1; c0 = cyc;
    push_run(1, c0, 1, 2, 2);
    tick(1); start1 = 1'b0;
    tick(2); rst = 1'b1;
    tick(1); rst = 1'b0;
    check("rst_mid_run_outputs", {reg_en1, src1, busy1, done1, iter_cnt1}, 0);
    tick(2);
    check_empty("run_rst");
    cfg1 = 4'd2; start1 = 1'b1; c0 = cyc;
    push_run(1, c0, 1, 2, -1);
    tick(1); start1 = 1'b0;
    tick(10);
    check_empty("run_after_rst");
    check("iter_after_rst", iter_cnt1, 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
